// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and constants for the LFSR sequencer: FSM state encoding and
// default widths.
package lfsr_seq_ctrl_pkg;

   localparam int SHIFT_BITS = 8;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/lfsr_bit_deser.sv
// LSB-first serial-to-parallel register. The first captured bit ends up in bit 0
// once WIDTH captures have been taken.
module lfsr_bit_deser
   import lfsr_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = lfsr_seq_ctrl_pkg::SHIFT_BITS
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clr,
   input  logic             cap,
   input  logic             din,
   output logic [WIDTH-1:0] data
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         data <= '0;
      end else if (clr) begin
         data <= '0;
      end else if (cap) begin
         data <= {din, data[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 8-bit Galois LFSR core: runs N step cycles, shifts the
// register out serially, and returns the rebuilt byte on a valid/ready channel.
module lfsr_seq_ctrl
   import lfsr_seq_ctrl_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SHIFT_BITS = lfsr_seq_ctrl_pkg::SHIFT_BITS
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CNT_W-1:0]      req_cycles,
   input  logic                  abort,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [SHIFT_BITS-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  lfsr_en,
   output logic                  lfsr_out_en,
   input  logic                  lfsr_out,
   input  logic                  lfsr_valid
);

   localparam int BIT_CNT_W = $clog2(SHIFT_BITS) + 1;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       step_cnt;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   accept;
   logic                   abort_hit;
   logic                   capture;

   assign accept    = (state == ST_IDLE) && req_valid;
   assign abort_hit = abort && (state inside {ST_RUN, ST_SHIFT, ST_DRAIN});
   // The core registers its serial output, so each bit lands one cycle after its enable.
   assign capture   = ((state == ST_SHIFT) && (bit_cnt != '0)) || (state == ST_DRAIN);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (req_valid) state_nxt = (req_cycles != '0) ? ST_RUN : ST_SHIFT;
         ST_RUN:   if (step_cnt == CNT_W'(1)) state_nxt = ST_SHIFT;
         ST_SHIFT: if (bit_cnt == BIT_CNT_W'(SHIFT_BITS - 1)) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort_hit) state_nxt = ST_IDLE;
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      req_ready   = 1'b0;
      busy        = 1'b1;
      rsp_valid   = 1'b0;
      lfsr_en     = 1'b0;
      lfsr_out_en = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_RUN:   lfsr_en     = 1'b1;
         ST_SHIFT: lfsr_out_en = 1'b1;
         ST_RESP:  rsp_valid   = 1'b1;
         default:  ;
      endcase
   end

   // The bit counter sits at zero outside SHIFT, which clears it on every entry.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         step_cnt <= '0;
         bit_cnt  <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (accept) begin
            step_cnt <= req_cycles;
         end else if (state == ST_RUN) begin
            step_cnt <= step_cnt - CNT_W'(1);
         end

         if (state == ST_SHIFT) begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         end else begin
            bit_cnt <= '0;
         end

         if ((state == ST_DRAIN) && !abort) begin
            rsp_err <= ~lfsr_valid;
         end
      end
   end

   lfsr_bit_deser #(
      .WIDTH (SHIFT_BITS)
   ) u_deser (
      .Clock (Clock),
      .Reset (Reset),
      .clr   (accept),
      .cap   (capture),
      .din   (lfsr_out),
      .data  (rsp_data)
   );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl paired with a behavioural model of the 8-bit Galois
// LFSR core; responses are checked against a queue of hand-computed expectations.
module tb_lfsr_seq_ctrl;
   import lfsr_seq_ctrl_pkg::*;

   localparam int CNT_W = 8;
   localparam int SB    = 8;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [CNT_W-1:0] req_cycles = '0;
   logic             abort = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [SB-1:0]    rsp_data;
   logic             rsp_err;
   logic             busy;
   logic             lfsr_en;
   logic             lfsr_out_en;
   logic             lfsr_out;
   logic             lfsr_valid;

   always #5 Clock = ~Clock;

   lfsr_seq_ctrl #(
      .CNT_W      (CNT_W),
      .SHIFT_BITS (SB)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cycles  (req_cycles),
      .abort       (abort),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .lfsr_en     (lfsr_en),
      .lfsr_out_en (lfsr_out_en),
      .lfsr_out    (lfsr_out),
      .lfsr_valid  (lfsr_valid)
   );

   // Core model: left-shifting Galois step with taps 8'hAB (an all-zero register
   // escapes by injecting the taps), right shift-out with registered serial bit.
   logic [7:0] seed = 8'hA5;
   logic [7:0] core_q;
   logic       core_fault = 1'b0;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         core_q     <= seed;
         lfsr_out   <= 1'b0;
         lfsr_valid <= 1'b0;
      end else begin
         lfsr_valid <= !core_fault;
         if (lfsr_en) begin
            core_q <= {core_q[6:0], 1'b0} ^ ((core_q[7] || core_q == 8'h00) ? 8'hAB : 8'h00);
         end else if (lfsr_out_en) begin
            lfsr_out <= core_q[0];
            core_q   <= {1'b0, core_q[7:1]};
         end
      end
   end

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
      int         steps;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   en_cnt = 0;
   int   en_base = 0;
   int   first_lat = 0;
   int   excl_viol = 0;
   logic seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge Clock) cyc <= cyc + 1;

   // Monitor: pops one expectation per response handshake.
   always @(negedge Clock) begin
      exp_t e;
      if (lfsr_en) en_cnt++;
      if (lfsr_en && lfsr_out_en) excl_viol++;
      if (!Reset) begin
         seen = 1'b0;
      end else if (rsp_valid) begin
         if (!seen) begin
            seen      = 1'b1;
            first_lat = cyc - acc_cyc;
         end
         if (rsp_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_data", 32'(rsp_data), 32'(e.data));
               check("rsp_err", 32'(rsp_err), 32'(e.err));
               check("latency", 32'(first_lat), 32'(e.lat));
               check("step_cycles", 32'(en_cnt - en_base), 32'(e.steps));
            end
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input int n, input logic [7:0] data, input logic err);
      exp_t e;
      @(negedge Clock);
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge Clock);
      e.data  = data;
      e.err   = err;
      e.lat   = n + 9;
      e.steps = n;
      sb_q.push_back(e);
      en_base    = en_cnt;
      req_cycles = CNT_W'(n);
      req_valid  = 1'b1;
      @(posedge Clock);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge Clock);
         if (!busy && sb_q.size() == 0) return;
      end
      check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic reset_core(input logic [7:0] s);
      @(negedge Clock);
      seed  = s;
      Reset = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_lfsr_en"}, 32'(lfsr_en), 32'd0);
      check({tag, "_lfsr_out_en"}, 32'(lfsr_out_en), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic any_rsp;
      #1;
      check_reset_vals("por");
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b1;

      // Zero steps: the seed comes straight back, nine cycles after acceptance.
      issue(0, 8'hA5, 1'b0);
      wait_idle();

      // One step from 01 gives 02; the consumed (zero) core then escapes to AB.
      reset_core(8'h01);
      issue(1, 8'h02, 1'b0);
      wait_idle();
      issue(1, 8'hAB, 1'b0);
      wait_idle();

      reset_core(8'h00);
      issue(1, 8'hAB, 1'b0);
      wait_idle();

      // 80 -> AB -> FD.
      reset_core(8'h80);
      issue(2, 8'hFD, 1'b0);
      wait_idle();

      // Core valid flag low at final capture.
      core_fault = 1'b1;
      reset_core(8'hA5);
      issue(0, 8'hA5, 1'b1);
      wait_idle();
      core_fault = 1'b0;

      // Back-pressure: response held for 5 cycles while a new request is offered.
      reset_core(8'h3C);
      rsp_ready = 1'b0;
      issue(0, 8'h3C, 1'b0);
      for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge Clock);
      check("hold_rsp_valid_seen", 32'(rsp_valid), 32'd1);
      req_cycles = 8'd5;
      req_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         check("hold_rsp_data", 32'(rsp_data), 32'h3C);
         check("hold_rsp_err", 32'(rsp_err), 32'd0);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      // Abort on the third SHIFT cycle; the core is left holding A5 >> 3.
      reset_core(8'hA5);
      @(negedge Clock);
      req_cycles = 8'd0;
      req_valid  = 1'b1;
      @(posedge Clock);
      #1;
      req_valid = 1'b0;
      @(posedge Clock);
      #1;
      @(posedge Clock);
      #1;
      check("abort_in_shift", 32'(lfsr_out_en), 32'd1);
      abort = 1'b1;
      @(posedge Clock);
      #1;
      abort = 1'b0;
      check("abort_lfsr_en", 32'(lfsr_en), 32'd0);
      check("abort_lfsr_out_en", 32'(lfsr_out_en), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      any_rsp = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (rsp_valid) any_rsp = 1'b1;
      end
      check("abort_no_rsp", 32'(any_rsp), 32'd0);
      issue(0, 8'h14, 1'b0);
      wait_idle();

      // Reset dropped in the middle of a long RUN.
      @(negedge Clock);
      req_cycles = 8'd200;
      req_valid  = 1'b1;
      @(posedge Clock);
      #1;
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) @(negedge Clock);
      check("midrun_lfsr_en", 32'(lfsr_en), 32'd1);
      seed  = 8'hA5;
      Reset = 1'b0;
      #1;
      check_reset_vals("midrun_rst");
      @(negedge Clock);
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge Clock);

      check("enable_exclusive", 32'(excl_viol), 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencer for the team's 8-bit Galois LFSR core. It accepts a request carrying a step count and drives the core's step enable for that many cycles. It then drives the core's shift-out enable for 8 cycles, deserialises the core's serial output into a byte, and returns that byte on a valid/ready response channel. It sits between a software/CSR front end and the LFSR core, and is the only agent driving the core's two enables.

## Interface
Parameters:
- CNT_W, 8, width of the requested step count.
- SHIFT_BITS, 8, number of shift-out cycles per request; equals the LFSR width.

Ports:
- Clock  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_cycles  in  CNT_W  number of LFSR step cycles to run before shift-out; 0 is legal.
- abort  in  1  synchronous abort of an in-flight request.
- rsp_valid  out  1  response byte available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  SHIFT_BITS  deserialised byte, LSB is the first bit shifted out.
- rsp_err  out  1  core's valid flag was low at final capture.
- busy  out  1  high in any state other than IDLE.
- lfsr_en  out  1  drives the core's step enable.
- lfsr_out_en  out  1  drives the core's shift-out enable.
- lfsr_out  in  1  core's registered serial output.
- lfsr_valid  in  1  core's registered valid flag.

## Operation
- States:
  - IDLE, RUN, SHIFT, DRAIN, RESP.
  - Encoding lives in the package.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_cycles into the step counter.
  - Go to RUN if the count is nonzero, else go to SHIFT.
- RUN:
  - lfsr_en=1.
  - Counter decrements each cycle.
  - Leave for SHIFT after exactly req_cycles cycles at lfsr_en=1.
- SHIFT:
  - lfsr_out_en=1 for exactly SHIFT_BITS cycles, tracked by a bit counter that is cleared on entry.
  - Then go to DRAIN.
- Capture:
  - lfsr_out is registered in the core, so it is sampled one cycle after each lfsr_out_en cycle.
  - Sampling happens in SHIFT cycles 2..8 and in DRAIN.
  - Each sample does shreg <= {lfsr_out, shreg[7:1]}.
- DRAIN:
  - One cycle, with both enables low.
  - Takes the final capture.
  - rsp_err is loaded with ~lfsr_valid.
  - Go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_err are held stable until rsp_ready.
  - Return to IDLE on the cycle where rsp_valid&rsp_ready.
- lfsr_en and lfsr_out_en are never high in the same cycle.
- Both enables are combinational decodes of the registered state and are glitch-free per cycle.
- abort:
  - Sampled in RUN, SHIFT or DRAIN.
  - The next state is IDLE, the enables drop on the following cycle, and no response is produced.
  - abort is ignored in IDLE and RESP.
- After a shift-out the core register is consumed. A follow-on request continues from whatever state the core holds; the controller does not re-seed.

## Timing
- Reset values:
  - state=IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - busy=0.
  - lfsr_en=0, lfsr_out_en=0.
  - Counters are 0.
- Reset asserted mid-operation returns the block to IDLE asynchronously. The enables drop immediately and any pending response is discarded.
- Latency: take the edge that accepts the request as E0. rsp_valid is first high in the cycle following edge E0+req_cycles+SHIFT_BITS+1, i.e. req_cycles+9 cycles later for the default configuration.
- Throughput: one request in flight. req_ready is low from the acceptance edge until the response is taken.
- A request offered in the same cycle as a response handshake is not accepted until the next cycle, when the block is in IDLE.
- Counter widths:
  - The step counter is CNT_W bits, so the maximum is 2^CNT_W-1 steps.
  - The bit counter is $clog2(SHIFT_BITS)+1 bits.

## Structure
- Package lfsr_seq_ctrl_pkg holds:
  - the state enum;
  - SHIFT_BITS;
  - the default CNT_W.
- Sub-module lfsr_bit_deser is an SHIFT_BITS-wide LSB-first serial-to-parallel register with a capture enable and synchronous clear.
- The FSM and counters live in the top module.

## Test plan
The bench pairs the controller with the LFSR core on a shared Reset/Clock, with the core seeded via its Seed input.
- Seed 8'hA5, req_cycles=0 → rsp_data=8'hA5, rsp_err=0, rsp_valid first high 9 cycles after acceptance.
- Seed 8'h01, req_cycles=1 → exactly one lfsr_en cycle, rsp_data=8'h02.
- Seed 8'h00, req_cycles=1 → rsp_data=8'hAB.
- rsp_ready held low 5 cycles in RESP → rsp_data/rsp_err stable, req_ready=0, new req_valid not accepted.
- abort pulsed on the third SHIFT cycle → both enables low next cycle, state IDLE, no rsp_valid; a later request is still accepted.
- Reset dropped mid-RUN with req_cycles=200 → all outputs at reset values immediately. Assert lfsr_en&lfsr_out_en never true throughout all tests.
